vector_reg_file: RTL and testbench
==================================

VECTOR_REG_FILE -- requirements
Module: vector_reg_file

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of vector registers (power of two, >=2).
REQ-002 SHALL have parameter ELEM_W, default 32, element width in bits.
REQ-003 SHALL have parameter NUM_ELEMS, default 16, elements per vector; VLEN = ELEM_W*NUM_ELEMS (512 default); SEL_W = log2(NUM_REGS).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports write_en / write_en2  input  1  write strobes, port 1 / port 2.
REQ-007 SHALL have ports write_sel / write_sel2  input  SEL_W  destination registers.
REQ-008 SHALL have ports write_data / write_data2  input  VLEN  write vectors, element i at bits [i*ELEM_W +: ELEM_W].
REQ-009 SHALL have ports write_mask / write_mask2  input  NUM_ELEMS  per-element write enables.
REQ-010 SHALL have ports read_sel / read_sel2  input  SEL_W  read selects.
REQ-011 SHALL have ports read_data / read_data2  output  VLEN  read vectors.
REQ-012 SHALL have port all_regs  output  NUM_REGS*VLEN  flat view; register r at [r*VLEN +: VLEN].
REQ-013 SHALL have ports rsv_en  input  1  and rsv_sel  input  SEL_W  scoreboard reservation request.
REQ-014 SHALL have port rsv_ack  output  1  registered; high one cycle after an accepted reservation.
REQ-015 SHALL have port busy  output  NUM_REGS  registered pending-write bit per register.
REQ-016 SHALL have port conflict_err  output  1  sticky flag.

Function
REQ-017 An element SHALL be written only when its port enable and mask bit are both 1; unmasked elements SHALL hold.
REQ-018 When both ports target the same register and element in one cycle, port 2 data SHALL win; non-overlapping elements from both ports SHALL both land.
REQ-019 Reads SHALL be combinational from stored state; a write is visible on read_data/read_data2/all_regs the cycle after its clock edge (no bypass).
REQ-020 Reservation SHALL be accepted when rsv_en=1 and busy[rsv_sel]=0, or busy[rsv_sel]=1 and a write retires it that same cycle; accepted -> busy[rsv_sel]=1 next cycle, rsv_ack=1 next cycle.
REQ-021 A reservation to a busy register not retired that cycle SHALL be rejected: busy unchanged, rsv_ack=0 next cycle; requester retries.
REQ-022 Any write with nonzero mask SHALL clear busy[write_sel] (resp. write_sel2) at the next edge, unless REQ-020 re-reserves it the same cycle (set wins).
REQ-023 A write with all-zero mask SHALL not modify data nor busy.
REQ-024 Both write ports enabled, same register, overlapping masks SHALL set conflict_err=1; it holds until reset.
REQ-025 A write to a register whose busy bit is 0 SHALL be legal (no error); scoreboard is advisory.

Reset
REQ-026 While reset=1, all registers, busy, rsv_ack and conflict_err SHALL be 0 immediately, independent of clk.
REQ-027 Reset asserted mid-operation SHALL drop pending reservations and in-flight writes of that edge; first write accepted on first rising edge after deassertion.

Structure
REQ-028 Package vrf_pkg SHALL hold default NUM_REGS/ELEM_W/NUM_ELEMS and derived VLEN/SEL_W constants.
REQ-029 Scoreboard (busy, rsv_ack, REQ-020..022) SHALL be sub-module vrf_scoreboard; data array and merge logic stay in vector_reg_file.

Verification
REQ-030 Reset then read all regs -> read_data=0, busy=0, conflict_err=0.
REQ-031 write_en=1, sel=2, data elem i = i, mask=16'h00FF -> next cycle reg2 elems 0..7 = 0..7, elems 8..15 = 0.
REQ-032 Both ports sel=1, mask 16'h000F / 16'h0003, data all 0xAAAAAAAA / 0x55555555 -> elems 0,1 = 0x55555555, elems 2,3 = 0xAAAAAAAA, conflict_err=1.
REQ-033 rsv sel=3 -> rsv_ack=1, busy=4'b1000; rsv sel=3 again -> rsv_ack=0; write sel=3 mask 16'h0001 -> busy=4'b0000.
REQ-034 Same cycle: write sel=0 (busy) plus rsv sel=0 -> rsv_ack=1, busy[0] stays 1, data updated.
REQ-035 Async reset pulse between edges with busy=4'b0110 and regs nonzero -> all outputs 0 before next edge.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared constants for the vector register file.
// Holds the default geometry (register count, element width, elements per
// vector) and the derived vector width and register-select width.
package vrf_pkg;

  localparam int unsigned NUM_REGS_DEF  = 4;
  localparam int unsigned ELEM_W_DEF    = 32;
  localparam int unsigned NUM_ELEMS_DEF = 16;
  localparam int unsigned VLEN_DEF      = ELEM_W_DEF * NUM_ELEMS_DEF;
  localparam int unsigned SEL_W_DEF     = $clog2(NUM_REGS_DEF);

endpackage

// File: rtl/vrf_scoreboard.sv
// Register reservation scoreboard.
// Tracks one pending-write (busy) bit per register. A reservation is taken
// when the register is free, or when a write retires it in the same cycle.
// Retiring writes clear busy; a same-cycle reservation re-sets it.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   rsv_en/sel   - reservation request and target register
//   retire       - per-register "write with nonzero mask this cycle"
//   busy         - registered pending-write bits
//   rsv_ack      - registered, high the cycle after an accepted reservation
module vrf_scoreboard
  import vrf_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  localparam int unsigned SEL_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rsv_en,
  input  logic [SEL_W-1:0]    rsv_sel,
  input  logic [NUM_REGS-1:0] retire,
  output logic [NUM_REGS-1:0] busy,
  output logic                rsv_ack
);

  logic                accept;
  logic [NUM_REGS-1:0] busy_next;

  always_comb begin
    accept    = rsv_en && (!busy[rsv_sel] || retire[rsv_sel]);
    busy_next = busy & ~retire;
    // Set after clear so a re-reservation of a retiring register wins.
    if (accept) begin
      busy_next[rsv_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= '0;
      rsv_ack <= 1'b0;
    end else begin
      busy    <= busy_next;
      rsv_ack <= accept;
    end
  end

endmodule

// File: rtl/vector_reg_file.sv
// Dual-write-port, dual-read-port vector register file with per-element
// write masks, a flat view of all registers, a reservation scoreboard and a
// sticky same-element write conflict flag.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   write_en/_sel/_data/_mask  - write port 1 (and *2 for port 2; port 2 wins)
//   read_sel/read_sel2         - read selects; read_data/read_data2 outputs
//   all_regs                   - register r at [r*VLEN +: VLEN]
//   rsv_en/rsv_sel/rsv_ack     - reservation request / acknowledge
//   busy                       - pending-write bit per register
//   conflict_err               - sticky: both ports hit same register element
module vector_reg_file
  import vrf_pkg::*;
#(
  parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
  parameter int unsigned ELEM_W    = ELEM_W_DEF,
  parameter int unsigned NUM_ELEMS = NUM_ELEMS_DEF,
  localparam int unsigned VLEN     = ELEM_W * NUM_ELEMS,
  localparam int unsigned SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_en,
  input  logic                     write_en2,
  input  logic [SEL_W-1:0]         write_sel,
  input  logic [SEL_W-1:0]         write_sel2,
  input  logic [VLEN-1:0]          write_data,
  input  logic [VLEN-1:0]          write_data2,
  input  logic [NUM_ELEMS-1:0]     write_mask,
  input  logic [NUM_ELEMS-1:0]     write_mask2,
  input  logic [SEL_W-1:0]         read_sel,
  input  logic [SEL_W-1:0]         read_sel2,
  output logic [VLEN-1:0]          read_data,
  output logic [VLEN-1:0]          read_data2,
  output logic [NUM_REGS*VLEN-1:0] all_regs,
  input  logic                     rsv_en,
  input  logic [SEL_W-1:0]         rsv_sel,
  output logic                     rsv_ack,
  output logic [NUM_REGS-1:0]      busy,
  output logic                     conflict_err
);

  logic [VLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] retire;
  logic                conflict;

  always_comb begin
    retire = '0;
    if (write_en && (|write_mask)) begin
      retire[write_sel] = 1'b1;
    end
    if (write_en2 && (|write_mask2)) begin
      retire[write_sel2] = 1'b1;
    end
    conflict = write_en && write_en2 && (write_sel == write_sel2)
               && (|(write_mask & write_mask2));
  end

  // Port 2 element updates are scheduled after port 1, so the later
  // non-blocking assignment gives port 2 priority on overlapping elements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int unsigned e = 0; e < NUM_ELEMS; e++) begin
        if (write_en && write_mask[e]) begin
          regs[write_sel][e*ELEM_W +: ELEM_W] <= write_data[e*ELEM_W +: ELEM_W];
        end
        if (write_en2 && write_mask2[e]) begin
          regs[write_sel2][e*ELEM_W +: ELEM_W] <= write_data2[e*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_err <= 1'b0;
    end else if (conflict) begin
      conflict_err <= 1'b1;
    end
  end

  assign read_data  = regs[read_sel];
  assign read_data2 = regs[read_sel2];

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
    assign all_regs[r*VLEN +: VLEN] = regs[r];
  end

  vrf_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .rsv_en  (rsv_en),
    .rsv_sel (rsv_sel),
    .retire  (retire),
    .busy    (busy),
    .rsv_ack (rsv_ack)
  );

endmodule

// File: tb/tb_vector_reg_file.sv
// Self-checking bench for vector_reg_file: directed scenarios followed by
// randomized traffic, compared against an element-level reference model.
module tb_vector_reg_file;

  localparam int NR   = 4;
  localparam int EW   = 32;
  localparam int NE   = 16;
  localparam int VLEN = EW * NE;
  localparam int SW   = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               write_en, write_en2;
  logic [SW-1:0]      write_sel, write_sel2;
  logic [VLEN-1:0]    write_data, write_data2;
  logic [NE-1:0]      write_mask, write_mask2;
  logic [SW-1:0]      read_sel, read_sel2;
  logic [VLEN-1:0]    read_data, read_data2;
  logic [NR*VLEN-1:0] all_regs;
  logic               rsv_en;
  logic [SW-1:0]      rsv_sel;
  logic               rsv_ack;
  logic [NR-1:0]      busy;
  logic               conflict_err;

  int errors = 0;
  int checks = 0;

  // Reference model: registers as arrays of elements.
  logic [EW-1:0] m [NR][NE];
  logic [NR-1:0] m_busy;
  logic          m_ack;
  logic          m_conf;

  vector_reg_file #(
    .NUM_REGS  (NR),
    .ELEM_W    (EW),
    .NUM_ELEMS (NE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write_en     (write_en),
    .write_en2    (write_en2),
    .write_sel    (write_sel),
    .write_sel2   (write_sel2),
    .write_data   (write_data),
    .write_data2  (write_data2),
    .write_mask   (write_mask),
    .write_mask2  (write_mask2),
    .read_sel     (read_sel),
    .read_sel2    (read_sel2),
    .read_data    (read_data),
    .read_data2   (read_data2),
    .all_regs     (all_regs),
    .rsv_en       (rsv_en),
    .rsv_sel      (rsv_sel),
    .rsv_ack      (rsv_ack),
    .busy         (busy),
    .conflict_err (conflict_err)
  );

  always #5 clk = ~clk;

  function automatic logic [VLEN-1:0] model_vec(int r);
    logic [VLEN-1:0] v;
    for (int e = 0; e < NE; e++) v[e*EW +: EW] = m[r][e];
    return v;
  endfunction

  task automatic check(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++)
      for (int e = 0; e < NE; e++) m[r][e] = '0;
    m_busy = '0;
    m_ack  = 1'b0;
    m_conf = 1'b0;
  endtask

  // Apply the effect of one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic [NR-1:0] retired;
    logic          acc;
    if (reset) begin
      model_reset();
      return;
    end
    retired = '0;
    for (int e = 0; e < NE; e++) begin
      if (write_en && write_mask[e])   m[write_sel][e]  = write_data[e*EW +: EW];
      if (write_en2 && write_mask2[e]) m[write_sel2][e] = write_data2[e*EW +: EW];
    end
    if (write_en && write_mask != 0)   retired[write_sel]  = 1'b1;
    if (write_en2 && write_mask2 != 0) retired[write_sel2] = 1'b1;
    acc = rsv_en && (!m_busy[rsv_sel] || retired[rsv_sel]);
    m_busy = m_busy & ~retired;
    if (acc) m_busy[rsv_sel] = 1'b1;
    m_ack = acc;
    if (write_en && write_en2 && write_sel == write_sel2 && (write_mask & write_mask2) != 0)
      m_conf = 1'b1;
  endtask

  task automatic check_all(input string where);
    for (int r = 0; r < NR; r++)
      check($sformatf("%s all_regs[%0d]", where, r), all_regs[r*VLEN +: VLEN], model_vec(r));
    check({where, " read_data"},  read_data,  model_vec(int'(read_sel)));
    check({where, " read_data2"}, read_data2, model_vec(int'(read_sel2)));
    check({where, " busy"},         VLEN'(busy),         VLEN'(m_busy));
    check({where, " rsv_ack"},      VLEN'(rsv_ack),      VLEN'(m_ack));
    check({where, " conflict_err"}, VLEN'(conflict_err), VLEN'(m_conf));
  endtask

  task automatic idle();
    write_en = 0; write_en2 = 0; write_sel = 0; write_sel2 = 0;
    write_data = '0; write_data2 = '0; write_mask = '0; write_mask2 = '0;
    rsv_en = 0; rsv_sel = 0;
  endtask

  task automatic step(input string where);
    @(posedge clk);
    model_edge();
    #1;
    check_all(where);
  endtask

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] v;
    for (int e = 0; e < NE; e++) v[e*EW +: EW] = $urandom;
    return v;
  endfunction

  initial begin
    logic [VLEN-1:0] v;
    idle();
    read_sel = 0; read_sel2 = 0;

    // Reset state
    reset = 1'b1;
    model_reset();
    #3;
    check_all("reset");
    for (int r = 0; r < NR; r++) begin
      read_sel = SW'(r);
      #1;
      check($sformatf("reset read reg%0d", r), read_data, '0);
    end
    reset = 1'b0;
    step("post reset idle");

    // Masked write: lower 8 elements of reg2 get their index
    for (int e = 0; e < NE; e++) v[e*EW +: EW] = EW'(e);
    write_en = 1; write_sel = 2; write_data = v; write_mask = 16'h00FF;
    read_sel = 2; read_sel2 = 0;
    step("masked write");
    idle();
    check("masked write elem7", VLEN'(read_data[7*EW +: EW]), VLEN'(7));
    check("masked write elem8", VLEN'(read_data[8*EW +: EW]), '0);

    // Dual write to the same register with overlapping masks
    write_en = 1; write_sel = 1; write_data = {NE{32'hAAAAAAAA}}; write_mask = 16'h000F;
    write_en2 = 1; write_sel2 = 1; write_data2 = {NE{32'h55555555}}; write_mask2 = 16'h0003;
    read_sel = 1;
    step("dual write");
    idle();
    check("dual elem1", VLEN'(read_data[1*EW +: EW]), VLEN'(32'h55555555));
    check("dual elem2", VLEN'(read_data[2*EW +: EW]), VLEN'(32'hAAAAAAAA));
    check("dual conflict", VLEN'(conflict_err), VLEN'(1));

    // Reservation accept / reject / retire
    rsv_en = 1; rsv_sel = 3;
    step("rsv3");
    check("rsv3 busy", VLEN'(busy), VLEN'(4'b1000));
    check("rsv3 ack", VLEN'(rsv_ack), VLEN'(1));
    step("rsv3 again");
    check("rsv3 reject ack", VLEN'(rsv_ack), VLEN'(0));
    idle();
    write_en = 1; write_sel = 3; write_data = rand_vec(); write_mask = 16'h0001;
    read_sel = 3;
    step("retire3");
    idle();
    check("retire3 busy", VLEN'(busy), VLEN'(4'b0000));

    // Same-cycle retire and re-reserve of reg0
    rsv_en = 1; rsv_sel = 0;
    step("rsv0");
    write_en = 1; write_sel = 0; write_data = rand_vec(); write_mask = 16'hFFFF;
    read_sel = 0;
    step("rsv0 during write");
    idle();
    check("rerserve ack", VLEN'(rsv_ack), VLEN'(1));
    check("rerserve busy0", VLEN'(busy[0]), VLEN'(1));

    // Asynchronous reset between edges with busy = 0110
    rsv_en = 1; rsv_sel = 0;                 // reg0 busy: retire it first
    write_en = 1; write_sel = 0; write_data = rand_vec(); write_mask = 16'h0F0F;
    step("prep w0");
    idle();
    write_en = 1; write_sel = 0; write_mask = 16'h0001; write_data = rand_vec();
    rsv_en = 1; rsv_sel = 1;
    step("prep rsv1");
    idle();
    rsv_en = 1; rsv_sel = 2;
    step("prep rsv2");
    idle();
    check("pre-reset busy", VLEN'(busy), VLEN'(4'b0110));
    write_en = 1; write_sel = 1; write_data = rand_vec(); write_mask = 16'hFFFF;
    rsv_en = 1; rsv_sel = 3;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async reset");
    #1;
    reset = 1'b0;
    idle();
    step("after async reset");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      write_en    = ($urandom_range(0, 3) != 0);
      write_en2   = ($urandom_range(0, 2) == 0);
      write_sel   = SW'($urandom_range(0, NR-1));
      write_sel2  = SW'($urandom_range(0, NR-1));
      write_data  = rand_vec();
      write_data2 = rand_vec();
      write_mask  = ($urandom_range(0, 4) == 0) ? '0 : NE'($urandom);
      write_mask2 = ($urandom_range(0, 4) == 0) ? '0 : NE'($urandom);
      rsv_en      = $urandom_range(0, 1) != 0;
      rsv_sel     = SW'($urandom_range(0, NR-1));
      read_sel    = SW'($urandom_range(0, NR-1));
      read_sel2   = SW'($urandom_range(0, NR-1));
      reset       = ($urandom_range(0, 49) == 0);
      step("random");
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
